// File: rtl/fpu_addsub_operand_stage_pkg.sv
// Shared binary32 FPU definitions: field widths, rounding modes, operand/entry
// records and the skid-buffer state encoding.
package fpu_addsub_operand_stage_pkg;

  localparam int              EXP_W   = 8;
  localparam int              FRAC_W  = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              is_zero;
    logic              is_sub;
    logic              is_inf;
    logic              is_nan;
    logic              is_snan;
  } operand_t;

  typedef struct packed {
    operand_t         a;
    operand_t         b;
    logic             sub_op;
    logic [2:0]       rounding_mode;
    logic             eff_sub;
    logic             swap;
    logic [EXP_W-1:0] exp_diff;
  } entry_t;

  // Subnormals share the minimum normal exponent for alignment purposes.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] exp);
    return (exp == '0) ? EXP_W'(1) : exp;
  endfunction

endpackage

// File: rtl/fpu_operand_classify.sv
// Combinational unpack and class decode of one raw binary32 operand.
module fpu_operand_classify
  import fpu_addsub_operand_stage_pkg::*;
(
  input  logic [31:0] op,
  output operand_t    info
);

  logic exp_zero;
  logic exp_max;
  logic frac_zero;

  assign exp_zero  = (op[30:23] == '0);
  assign exp_max   = (op[30:23] == EXP_MAX);
  assign frac_zero = (op[22:0] == '0);

  always_comb begin
    info         = '0;
    info.sign    = op[31];
    info.exp     = op[30:23];
    info.frac    = op[22:0];
    info.is_zero = exp_zero & frac_zero;
    info.is_sub  = exp_zero & ~frac_zero;
    info.is_inf  = exp_max & frac_zero;
    info.is_nan  = exp_max & ~frac_zero;
    // Quiet bit clear marks a signaling NaN.
    info.is_snan = exp_max & ~frac_zero & ~op[22];
  end

endmodule

// File: rtl/fpu_addsub_operand_stage.sv
// Registered operand unpack/classify stage for FPU add/sub with a two-entry
// skid buffer: full throughput, in_ready registered, no out_ready->in_ready path.
module fpu_addsub_operand_stage
  import fpu_addsub_operand_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        sub_op_i,
  input  logic [2:0]  rounding_mode_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        sign_A_o,
  output logic        sign_B_o,
  output logic [7:0]  exp_A_o,
  output logic [7:0]  exp_B_o,
  output logic [22:0] sig_A_o,
  output logic [22:0] sig_B_o,
  output logic        isZeroA_o,
  output logic        isZeroB_o,
  output logic        isInfA_o,
  output logic        isInfB_o,
  output logic        isNaNA_o,
  output logic        isNaNB_o,
  output logic        isSubA_o,
  output logic        isSubB_o,
  output logic        isSignaling_o,
  output logic        sub_op_o,
  output logic [2:0]  rounding_mode_o,
  output logic        eff_sub_o,
  output logic        swap_o,
  output logic [7:0]  exp_diff_o
);

  operand_t         info_a;
  operand_t         info_b;
  entry_t           new_entry;
  entry_t           head;
  entry_t           skid;
  buf_state_e       state;
  logic [EXP_W-1:0] eexp_a;
  logic [EXP_W-1:0] eexp_b;
  logic             accept;
  logic             pop;

  fpu_operand_classify u_classify_a (.op(op_a_i), .info(info_a));
  fpu_operand_classify u_classify_b (.op(op_b_i), .info(info_b));

  assign eexp_a = eff_exp(info_a.exp);
  assign eexp_b = eff_exp(info_b.exp);

  always_comb begin
    new_entry               = '0;
    new_entry.a             = info_a;
    new_entry.b             = info_b;
    new_entry.sub_op        = sub_op_i;
    new_entry.rounding_mode = rounding_mode_i;
    new_entry.eff_sub       = info_a.sign ^ info_b.sign ^ sub_op_i;
    // Magnitude order is the plain unsigned order of {exp,frac}.
    new_entry.swap          = (op_b_i[30:0] > op_a_i[30:0]);
    new_entry.exp_diff      = (eexp_a >= eexp_b) ? (eexp_a - eexp_b) : (eexp_b - eexp_a);
  end

  assign in_ready_o  = (state != BUF_TWO);
  assign out_valid_o = (state != BUF_EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // NOTE: all state uses non-blocking assignment so every register samples
  // pre-edge values regardless of evaluation order.
  // NOTE: the data registers are reset as well, because the outputs must read
  // zero during reset; this is not a RAM, so the reset costs nothing special.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= BUF_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush_i) begin
      state <= BUF_EMPTY;
    end else begin
      unique case (state)
        BUF_EMPTY: begin
          if (accept) begin
            head  <= new_entry;
            state <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && pop) begin
            head <= new_entry;
          end else if (accept) begin
            skid  <= new_entry;
            state <= BUF_TWO;
          end else if (pop) begin
            state <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (pop) begin
            head  <= skid;
            state <= BUF_ONE;
          end
        end
        default: state <= BUF_EMPTY;
      endcase
    end
  end

  assign sign_A_o        = head.a.sign;
  assign sign_B_o        = head.b.sign;
  assign exp_A_o         = head.a.exp;
  assign exp_B_o         = head.b.exp;
  assign sig_A_o         = head.a.frac;
  assign sig_B_o         = head.b.frac;
  assign isZeroA_o       = head.a.is_zero;
  assign isZeroB_o       = head.b.is_zero;
  assign isInfA_o        = head.a.is_inf;
  assign isInfB_o        = head.b.is_inf;
  assign isNaNA_o        = head.a.is_nan;
  assign isNaNB_o        = head.b.is_nan;
  assign isSubA_o        = head.a.is_sub;
  assign isSubB_o        = head.b.is_sub;
  assign isSignaling_o   = head.a.is_snan | head.b.is_snan;
  assign sub_op_o        = head.sub_op;
  assign rounding_mode_o = head.rounding_mode;
  assign eff_sub_o       = head.eff_sub;
  assign swap_o          = head.swap;
  assign exp_diff_o      = head.exp_diff;

endmodule

// File: tb/tb_fpu_addsub_operand_stage.sv
// Randomized self-checking bench: a queue-based reference model of the
// two-entry buffer plus directed literal checks of classification and flow.
module tb_fpu_addsub_operand_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        sub_op_i;
  logic [2:0]  rounding_mode_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        sign_A_o, sign_B_o;
  logic [7:0]  exp_A_o, exp_B_o;
  logic [22:0] sig_A_o, sig_B_o;
  logic        isZeroA_o, isZeroB_o, isInfA_o, isInfB_o;
  logic        isNaNA_o, isNaNB_o, isSubA_o, isSubB_o;
  logic        isSignaling_o;
  logic        sub_op_o;
  logic [2:0]  rounding_mode_o;
  logic        eff_sub_o;
  logic        swap_o;
  logic [7:0]  exp_diff_o;

  fpu_addsub_operand_stage dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .sub_op_i(sub_op_i),
    .rounding_mode_i(rounding_mode_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .sign_A_o(sign_A_o), .sign_B_o(sign_B_o),
    .exp_A_o(exp_A_o), .exp_B_o(exp_B_o),
    .sig_A_o(sig_A_o), .sig_B_o(sig_B_o),
    .isZeroA_o(isZeroA_o), .isZeroB_o(isZeroB_o),
    .isInfA_o(isInfA_o), .isInfB_o(isInfB_o),
    .isNaNA_o(isNaNA_o), .isNaNB_o(isNaNB_o),
    .isSubA_o(isSubA_o), .isSubB_o(isSubB_o),
    .isSignaling_o(isSignaling_o),
    .sub_op_o(sub_op_o), .rounding_mode_o(rounding_mode_o),
    .eff_sub_o(eff_sub_o), .swap_o(swap_o), .exp_diff_o(exp_diff_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        za, zb, ia, ib, na, nb, ua, ub;
    logic        sig, sub;
    logic [2:0]  rm;
    logic        eff, swap;
    logic [7:0]  diff;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pops  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: fields derived directly from the IEEE-754 encoding rules.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic [2:0] rm);
    exp_t        e;
    int unsigned ma, mb, xa, xb;
    e    = '0;
    e.sa = a[31];  e.sb = b[31];
    e.ea = a[30:23]; e.eb = b[30:23];
    e.fa = a[22:0];  e.fb = b[22:0];
    e.za = (e.ea == 0)   && (e.fa == 0);
    e.ua = (e.ea == 0)   && (e.fa != 0);
    e.ia = (e.ea == 255) && (e.fa == 0);
    e.na = (e.ea == 255) && (e.fa != 0);
    e.zb = (e.eb == 0)   && (e.fb == 0);
    e.ub = (e.eb == 0)   && (e.fb != 0);
    e.ib = (e.eb == 255) && (e.fb == 0);
    e.nb = (e.eb == 255) && (e.fb != 0);
    e.sig = (e.na && e.fa < 23'h400000) || (e.nb && e.fb < 23'h400000);
    e.sub  = s;
    e.rm   = rm;
    e.eff  = (a[31] != b[31]) ? !s : s;
    ma = a & 32'h7FFF_FFFF;
    mb = b & 32'h7FFF_FFFF;
    e.swap = (mb > ma);
    xa = (e.ea == 0) ? 1 : e.ea;
    xb = (e.eb == 0) ? 1 : e.eb;
    e.diff = 8'((xa > xb) ? (xa - xb) : (xb - xa));
    return e;
  endfunction

  task automatic compare_head(input exp_t e);
    check("sign_A", 32'(sign_A_o), 32'(e.sa));
    check("sign_B", 32'(sign_B_o), 32'(e.sb));
    check("exp_A", 32'(exp_A_o), 32'(e.ea));
    check("exp_B", 32'(exp_B_o), 32'(e.eb));
    check("sig_A", 32'(sig_A_o), 32'(e.fa));
    check("sig_B", 32'(sig_B_o), 32'(e.fb));
    check("isZeroA", 32'(isZeroA_o), 32'(e.za));
    check("isZeroB", 32'(isZeroB_o), 32'(e.zb));
    check("isInfA", 32'(isInfA_o), 32'(e.ia));
    check("isInfB", 32'(isInfB_o), 32'(e.ib));
    check("isNaNA", 32'(isNaNA_o), 32'(e.na));
    check("isNaNB", 32'(isNaNB_o), 32'(e.nb));
    check("isSubA", 32'(isSubA_o), 32'(e.ua));
    check("isSubB", 32'(isSubB_o), 32'(e.ub));
    check("isSignaling", 32'(isSignaling_o), 32'(e.sig));
    check("sub_op", 32'(sub_op_o), 32'(e.sub));
    check("rounding_mode", 32'(rounding_mode_o), 32'(e.rm));
    check("eff_sub", 32'(eff_sub_o), 32'(e.eff));
    check("swap", 32'(swap_o), 32'(e.swap));
    check("exp_diff", 32'(exp_diff_o), 32'(e.diff));
  endtask

  // Model update on every edge: a FIFO of at most two entries.
  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      q.delete();
    end else if (flush_i) begin
      q.delete();
    end else begin
      automatic bit acc = in_valid_i && (q.size() < 2);
      automatic bit pp  = out_ready_i && (q.size() > 0);
      if (pp) begin
        void'(q.pop_front());
        n_pops++;
      end
      if (acc) q.push_back(model(op_a_i, op_b_i, sub_op_i, rounding_mode_i));
    end
  end

  // Compare on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (reset_i) begin
      check("in_ready", 32'(in_ready_o), 32'(q.size() < 2));
      check("out_valid", 32'(out_valid_o), 32'(q.size() > 0));
      if (q.size() > 0) compare_head(q[0]);
    end
  end

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input bit s, input logic [2:0] rm);
    in_valid_i = v; op_a_i = a; op_b_i = b; sub_op_i = s; rounding_mode_i = rm;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One input into a draining stage; returns with that entry at the head.
  task automatic apply_one(input logic [31:0] a, input logic [31:0] b, input bit s);
    out_ready_i = 1'b1;
    drive(1'b1, a, b, s, 3'b000);
    step();
    in_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom);
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    step(); step();
    check("reset in_ready", 32'(in_ready_o), 32'd1);
    check("reset out_valid", 32'(out_valid_o), 32'd0);
    check("reset exp_A", 32'(exp_A_o), 32'd0);
    reset_i = 1'b1;
    step();

    // Classification and derived terms, pinned by hand.
    apply_one(32'h0000_0000, 32'h7F80_0000, 1'b0);
    check("lit isZeroA", 32'(isZeroA_o), 32'd1);
    check("lit isInfB", 32'(isInfB_o), 32'd1);
    apply_one(32'h7FA0_0000, 32'h3F80_0000, 1'b0);
    check("lit isNaNA", 32'(isNaNA_o), 32'd1);
    check("lit sNaN", 32'(isSignaling_o), 32'd1);
    apply_one(32'h7FC0_0000, 32'h3F80_0000, 1'b0);
    check("lit qNaN not signaling", 32'(isSignaling_o), 32'd0);
    apply_one(32'h0000_0001, 32'h0080_0000, 1'b0);
    check("lit isSubA", 32'(isSubA_o), 32'd1);
    check("lit exp_diff sub vs min normal", 32'(exp_diff_o), 32'd0);
    apply_one(32'h3F80_0000, 32'h4040_0000, 1'b1);
    check("lit eff_sub", 32'(eff_sub_o), 32'd1);
    check("lit swap", 32'(swap_o), 32'd1);
    check("lit exp_diff", 32'(exp_diff_o), 32'd1);
    apply_one(32'h4040_0000, 32'h4040_0000, 1'b0);
    check("lit swap equal", 32'(swap_o), 32'd0);
    step();

    // Back-pressure: fill to two entries, third held off, then drain in order.
    out_ready_i = 1'b0;
    p0 = n_pops;
    drive(1'b1, 32'h3F80_0000, 32'h0, 1'b0, 3'b001);
    step();
    drive(1'b1, 32'h4000_0000, 32'h0, 1'b0, 3'b010);
    step();
    check("bp in_ready after 2", 32'(in_ready_o), 32'd0);
    check("bp out_valid", 32'(out_valid_o), 32'd1);
    drive(1'b1, 32'h4040_0000, 32'h0, 1'b0, 3'b011);
    step();
    check("bp head held", 32'(exp_A_o), 32'd127);
    check("bp rm held", 32'(rounding_mode_o), 32'd1);
    out_ready_i = 1'b1;
    step();
    check("bp second out", 32'(exp_A_o), 32'd128);
    check("bp second sig", 32'(sig_A_o), 32'd0);
    step();
    check("bp third out", 32'(sig_A_o), 32'h40_0000);
    in_valid_i = 1'b0;
    step();
    check("bp pops", 32'(n_pops - p0), 32'd3);

    // Streaming: 100 random pairs, one per cycle.
    p0 = n_pops;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, rand_op(), rand_op(), 1'($urandom), 3'($urandom_range(0, 4)));
      step();
      if (i == 0) check("stream latency", 32'(out_valid_o), 32'd1);
    end
    in_valid_i = 1'b0;
    step();
    check("stream pops", 32'(n_pops - p0), 32'd100);

    // Random back-pressure mix.
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom), 3'($urandom_range(0, 4)));
      out_ready_i = 1'($urandom_range(0, 2) != 0);
      step();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    step(); step(); step();

    // Flush in TWO with a concurrent input.
    out_ready_i = 1'b0;
    drive(1'b1, 32'h4100_0000, 32'h0, 1'b0, 3'b000);
    step();
    drive(1'b1, 32'h4110_0000, 32'h0, 1'b0, 3'b000);
    step();
    check("flush pre in_ready", 32'(in_ready_o), 32'd0);
    out_ready_i = 1'b1;
    drive(1'b1, 32'h4220_0000, 32'h0, 1'b0, 3'b000);
    flush_i = 1'b1;
    p0 = n_pops;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("flush out_valid", 32'(out_valid_o), 32'd0);
    check("flush in_ready", 32'(in_ready_o), 32'd1);
    step(); step(); step();
    check("flush nothing emitted", 32'(n_pops - p0), 32'd0);

    // Asynchronous reset between edges.
    out_ready_i = 1'b0;
    drive(1'b1, 32'hC1A0_0001, 32'h7FA0_0000, 1'b1, 3'b100);
    step();
    step();
    #2;
    reset_i = 1'b0;
    #1;
    check("areset out_valid", 32'(out_valid_o), 32'd0);
    check("areset in_ready", 32'(in_ready_o), 32'd1);
    check("areset data zero", 32'(|{sign_A_o, sign_B_o, exp_A_o, exp_B_o, sig_A_o, sig_B_o,
                                     isZeroA_o, isZeroB_o, isInfA_o, isInfB_o, isNaNA_o, isNaNB_o,
                                     isSubA_o, isSubB_o, isSignaling_o, sub_op_o, rounding_mode_o,
                                     eff_sub_o, swap_o, exp_diff_o}), 32'd0);
    in_valid_i = 1'b0;
    step();
    reset_i = 1'b1;
    drive(1'b1, 32'h3F80_0000, 32'h4040_0000, 1'b0, 3'b000);
    step();
    in_valid_i = 1'b0;
    check("post-reset out_valid", 32'(out_valid_o), 32'd1);
    check("post-reset exp_B", 32'(exp_B_o), 32'd128);
    out_ready_i = 1'b1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
